// File: rtl/ub_delay_pkg.sv
// rtl/ub_delay_pkg.sv - shared constants, word type and delay clamp for the multitap delay buffer
package ub_delay_pkg;

  localparam int UB_WIDTH = 16;
  localparam int UB_DEPTH = 64;

  typedef logic [UB_WIDTH-1:0] ub_word_t;

  // Legal delays are 1..depth; 0 and anything past the RAM size are pinned to the ends.
  function automatic int unsigned ub_clamp_delay(input int unsigned d, input int unsigned depth);
    if (d == 0) return 1;
    if (d > depth) return depth;
    return d;
  endfunction

endpackage

// File: rtl/ub_delay_tap.sv
// rtl/ub_delay_tap.sv - one read tap: latched delay, fill counter, read address and output registers
module ub_delay_tap
  import ub_delay_pkg::*;
#(
  parameter int WIDTH = UB_WIDTH,
  parameter int DEPTH = UB_DEPTH,
  parameter int DW    = $clog2(DEPTH) + 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             wen,
  input  logic             cfg_load,
  input  logic [DW-1:0]    cfg_delay,
  input  logic [AW-1:0]    wptr,
  input  logic [WIDTH-1:0] rword,
  output logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);

  logic [DW-1:0] dly;
  logic [DW-1:0] fill;

  // dly == DEPTH truncates to 0 here, so the tap reads the word about to be overwritten.
  assign raddr = wptr - dly[AW-1:0];

  always_ff @(posedge clk) begin
    if (flush) begin
      dly    <= DW'(1);
      fill   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (cfg_load) begin
      dly    <= DW'(ub_clamp_delay(32'(cfg_delay), DEPTH));
      fill   <= '0;
      rvalid <= 1'b0;
    end else if (wen) begin
      rdata  <= rword;
      rvalid <= (fill >= dly);
      if (fill < DW'(DEPTH)) fill <= fill + DW'(1);
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/ub_multitap_delay_buffer.sv
// rtl/ub_multitap_delay_buffer.sv - circular-RAM stream delay with NUM_RD independent taps
// Optional sticky cfg_err output when UB_DELAY_CHECK_EN is defined.
module ub_multitap_delay_buffer
  import ub_delay_pkg::*;
#(
  parameter int WIDTH  = UB_WIDTH,
  parameter int DEPTH  = UB_DEPTH,
  parameter int NUM_RD = 2,
  parameter int DW     = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         flush,
  input  logic                         wen,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         cfg_load,
  input  logic [NUM_RD-1:0][DW-1:0]    cfg_delay,
  output logic [NUM_RD-1:0][WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rvalid
`ifdef UB_DELAY_CHECK_EN
  ,
  output logic                         cfg_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]             mem [DEPTH];
  logic [AW-1:0]                wptr;
  logic [NUM_RD-1:0][AW-1:0]    raddr;
  logic [NUM_RD-1:0][WIDTH-1:0] rword;

  // A cfg_load cycle drops any concurrent write.
  always_ff @(posedge clk) begin
    if (!flush && wen && !cfg_load) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (flush) wptr <= '0;
    else if (wen && !cfg_load) wptr <= wptr + AW'(1);
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_tap
    assign rword[i] = mem[raddr[i]];

    ub_delay_tap #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .DW   (DW),
      .AW   (AW)
    ) u_tap (
      .clk      (clk),
      .flush    (flush),
      .wen      (wen),
      .cfg_load (cfg_load),
      .cfg_delay(cfg_delay[i]),
      .wptr     (wptr),
      .rword    (rword[i]),
      .raddr    (raddr[i]),
      .rdata    (rdata[i]),
      .rvalid   (rvalid[i])
    );
  end

`ifdef UB_DELAY_CHECK_EN
  logic any_clamp;

  always_comb begin
    any_clamp = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ub_clamp_delay(32'(cfg_delay[i]), DEPTH) != 32'(cfg_delay[i])) any_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) cfg_err <= 1'b0;
    else if (cfg_load && (any_clamp || wen)) cfg_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ub_multitap_delay_buffer.sv
// tb/tb_ub_multitap_delay_buffer.sv - directed and random checks of ub_multitap_delay_buffer against a write-history model
module tb_ub_multitap_delay_buffer;
  import ub_delay_pkg::*;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 64;
  localparam int NUM_RD = 2;
  localparam int DW     = $clog2(DEPTH) + 1;

  logic                         clk = 1'b0;
  logic                         flush;
  logic                         wen;
  logic [WIDTH-1:0]             wdata;
  logic                         cfg_load;
  logic [NUM_RD-1:0][DW-1:0]    cfg_delay;
  logic [NUM_RD-1:0][WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rvalid;
`ifdef UB_DELAY_CHECK_EN
  logic                         cfg_err;
`endif

  ub_multitap_delay_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NUM_RD(NUM_RD),
    .DW    (DW)
  ) dut (
    .clk      (clk),
    .flush    (flush),
    .wen      (wen),
    .wdata    (wdata),
    .cfg_load (cfg_load),
    .cfg_delay(cfg_delay),
    .rdata    (rdata),
    .rvalid   (rvalid)
`ifdef UB_DELAY_CHECK_EN
    ,
    .cfg_err  (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: every word written since the last flush, plus writes counted since the last restart.
  ub_word_t hist[$];
  int       nw;
  int       dly_m  [NUM_RD];
  bit       exp_rv [NUM_RD];
  ub_word_t exp_rd [NUM_RD];
  bit       known  [NUM_RD];
  bit       exp_err;

  function automatic int legal_delay(input int v);
    if (v < 1) return 1;
    if (v > DEPTH) return DEPTH;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit fl, input bit ld, input bit w, input ub_word_t wd,
                      input int d0, input int d1);
    int dreq [NUM_RD];
    dreq[0]   = d0;
    dreq[1]   = d1;
    flush     = fl;
    cfg_load  = ld;
    wen       = w;
    wdata     = wd;
    cfg_delay[0] = DW'(d0);
    cfg_delay[1] = DW'(d1);
    @(posedge clk);
    if (fl) begin
      hist.delete();
      nw      = 0;
      exp_err = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
        dly_m[i] = 1; exp_rv[i] = 1'b0; exp_rd[i] = '0; known[i] = 1'b1;
      end
    end else if (ld) begin
      nw = 0;
      if (w) exp_err = 1'b1;
      for (int i = 0; i < NUM_RD; i++) begin
        if (legal_delay(dreq[i]) != dreq[i]) exp_err = 1'b1;
        dly_m[i]  = legal_delay(dreq[i]);
        exp_rv[i] = 1'b0;
      end
    end else if (w) begin
      for (int i = 0; i < NUM_RD; i++) begin
        exp_rv[i] = (nw >= dly_m[i]);
        if (hist.size() >= dly_m[i]) begin
          exp_rd[i] = hist[hist.size() - dly_m[i]];
          known[i]  = 1'b1;
        end else begin
          known[i]  = 1'b0;
        end
      end
      hist.push_back(wd);
      nw++;
    end else begin
      for (int i = 0; i < NUM_RD; i++) exp_rv[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < NUM_RD; i++) begin
      chk($sformatf("rvalid[%0d]", i), 32'(rvalid[i]), 32'(exp_rv[i]));
      if (known[i]) chk($sformatf("rdata[%0d]", i), 32'(rdata[i]), 32'(exp_rd[i]));
    end
`ifdef UB_DELAY_CHECK_EN
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
`endif
  endtask

  initial begin
    int d0;
    int d1;
    flush = 1'b1; cfg_load = 1'b0; wen = 1'b0; wdata = '0; cfg_delay = '0;

    // reset state
    step(1, 0, 0, 16'h0, 0, 0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);

    // basic delays {1,3}
    step(0, 1, 0, 16'h0, 1, 3);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 1, ub_word_t'(k), 1, 3);
      if (k == 2) chk("basic_tap0_first", 32'({rvalid[0], rdata[0]}), 32'h1_0001);
      if (k == 3) chk("basic_tap1_off", 32'(rvalid[1]), 32'd0);
      if (k == 4) chk("basic_tap1_first", 32'({rvalid[1], rdata[1]}), 32'h1_0001);
    end

    // wrap and maximum delay
    step(1, 0, 0, 16'h0, 0, 0);
    step(0, 1, 0, 16'h0, 64, 5);
    for (int k = 1; k <= 200; k++) begin
      step(0, 0, 1, ub_word_t'(k - 1), 64, 5);
      if (k == 64) chk("wrap_not_yet", 32'(rvalid[0]), 32'd0);
      if (k == 65) chk("wrap_first", 32'({rvalid[0], rdata[0]}), 32'h1_0000);
      if (k == 200) chk("wrap_200", 32'({rvalid[0], rdata[0]}), 32'h1_0087);
    end

    // gapped stream with delay 2
    step(1, 0, 0, 16'h0, 0, 0);
    step(0, 1, 0, 16'h0, 2, 2);
    step(0, 0, 1, 16'hAAAA, 2, 2);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 16'h0, 2, 2);
    step(0, 0, 1, 16'hBBBB, 2, 2);
    chk("gap_b_invalid", 32'(rvalid[0]), 32'd0);
    step(0, 0, 1, 16'hCCCC, 2, 2);
    chk("gap_c_data", 32'({rvalid[0], rdata[0]}), 32'h1_AAAA);
    step(0, 0, 0, 16'h0, 2, 2);
    chk("gap_hold", 32'(rdata[0]), 32'hAAAA);

    // reconfiguration with a concurrent write, clamped delays
    for (int k = 0; k < 5; k++) step(0, 0, 1, ub_word_t'(16'h100 + k), 2, 2);
    step(0, 1, 1, 16'hDEAD, 0, 100);
    for (int k = 0; k < 70; k++) step(0, 0, 1, ub_word_t'(16'h200 + k), 0, 100);

    // flush mid-operation
    step(1, 0, 0, 16'h0, 0, 0);
    step(0, 1, 0, 16'h0, 1, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 1, ub_word_t'(16'h300 + k), 1, 1);
    step(1, 0, 1, 16'h3FF, 1, 1);
    chk("flush_clears", 32'({rvalid, rdata}), 32'd0);
    step(0, 0, 1, 16'h400, 1, 1);
    step(0, 0, 1, 16'h401, 1, 1);
    chk("flush_refill", 32'({rvalid[0], rdata[0]}), 32'h1_0400);

    // random traffic
    d0 = 1; d1 = 1;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        step(1, 0, 0, 16'h0, d0, d1);
      end else if (r < 15) begin
        d0 = int'($urandom_range(0, 2 * DEPTH - 1));
        d1 = int'($urandom_range(0, 2 * DEPTH - 1));
        step(0, 1, bit'($urandom_range(0, 1)), ub_word_t'($urandom), d0, d1);
      end else begin
        step(0, 0, (r % 4) != 0, ub_word_t'($urandom), d0, d1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
